// File: rtl/sc_stream_decoder.sv
// rtl/sc_stream_decoder.sv - windowed ones counter for a unipolar stochastic bit stream
// Optional edge counting on pulse_count is enabled by defining SC_DECODE_PULSECNT_EN.
module sc_stream_decoder #(
  parameter int WINDOW = 256,
  localparam int CW = $clog2(WINDOW + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bit_in,
  input  logic          start,
  input  logic          cont,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [CW-1:0] count_out,
  output logic [CW-1:0] pulse_count,
  output logic          overrun,
  output logic          busy
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

  state_t        state;
  logic [CW-1:0] acc;
  logic [CW-1:0] sample_cnt;
  logic [CW-1:0] acc_next;
  logic          last_sample;
  logic          result_held;
  logic          load_result;
  logic          window_start;

  assign acc_next     = acc + CW'(bit_in);
  assign last_sample  = (state == ACCUM) && (sample_cnt == LAST);
  assign result_held  = out_valid && !out_ready;
  // A result arriving while the previous one is still unaccepted is dropped.
  assign load_result  = last_sample && !result_held;
  assign window_start = (state == IDLE) && start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      acc        <= '0;
      sample_cnt <= '0;
      out_valid  <= 1'b0;
      count_out  <= '0;
      overrun    <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state      <= ACCUM;
            busy       <= 1'b1;
            acc        <= '0;
            sample_cnt <= '0;
            overrun    <= 1'b0;
          end
        end
        ACCUM: begin
          if (sample_cnt == LAST) begin
            if (result_held) begin
              overrun <= 1'b1;
            end else begin
              out_valid <= 1'b1;
              count_out <= acc_next;
            end
            acc        <= '0;
            sample_cnt <= '0;
            if (!cont) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            acc        <= acc_next;
            sample_cnt <= sample_cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SC_DECODE_PULSECNT_EN
  logic          prev_bit;
  logic [CW-1:0] edge_acc;
  logic [CW-1:0] edge_next;

  assign edge_next = edge_acc + CW'(bit_in & ~prev_bit);

  // prev_bit restarts at 0 each window so a leading 1 counts as an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_bit    <= 1'b0;
      edge_acc    <= '0;
      pulse_count <= '0;
    end else if (window_start) begin
      prev_bit <= 1'b0;
      edge_acc <= '0;
    end else if (state == ACCUM) begin
      if (last_sample) begin
        prev_bit <= 1'b0;
        edge_acc <= '0;
        if (load_result) begin
          pulse_count <= edge_next;
        end
      end else begin
        prev_bit <= bit_in;
        edge_acc <= edge_next;
      end
    end
  end
`else
  assign pulse_count = '0;
`endif

endmodule

// File: tb/tb_sc_stream_decoder.sv
// tb/tb_sc_stream_decoder.sv - self-checking bench for sc_stream_decoder with WINDOW=16
module tb_sc_stream_decoder;

  localparam int W = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          bit_in = 1'b0;
  logic          start = 1'b0;
  logic          cont = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [CW-1:0] count_out;
  logic [CW-1:0] pulse_count;
  logic          overrun;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  sc_stream_decoder #(.WINDOW(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .start      (start),
    .cont       (cont),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .count_out  (count_out),
    .pulse_count(pulse_count),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: population count and number of 0->1 transitions, first sample after a 0.
  function automatic logic [CW-1:0] model_ones(input logic [W-1:0] b);
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(b[i]);
    return CW'(n);
  endfunction

  function automatic logic [CW-1:0] model_edges(input logic [W-1:0] b);
    int n = 0;
`ifdef SC_DECODE_PULSECNT_EN
    for (int i = 0; i < W; i++)
      if (b[i] && (i == 0 || !b[i-1])) n++;
`endif
    return CW'(n);
  endfunction

  task automatic test_reset;
    rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    n_cmp++; if (count_out !== '0) begin n_bad++; $display("FAIL reset_count got=%0d want=0", count_out); end
    n_cmp++; if (pulse_count !== '0) begin n_bad++; $display("FAIL reset_pulse got=%0d want=0", pulse_count); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  // One single-shot window with the sink ready; checks latency, count and edges.
  task automatic single_window(input logic [W-1:0] b, input string name);
    cont = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL %s_busy got=%b want=1", name, busy); end
    for (int i = 0; i < W; i++) begin
      bit_in = b[i];
      tick();
      if (i == W - 2) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL %s_early_valid got=%b want=0", name, out_valid); end
      end
    end
    bit_in = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL %s_valid got=%b want=1", name, out_valid); end
    n_cmp++; if (count_out !== model_ones(b)) begin n_bad++; $display("FAIL %s_count got=%0d want=%0d", name, count_out, model_ones(b)); end
    n_cmp++; if (pulse_count !== model_edges(b)) begin n_bad++; $display("FAIL %s_pulse got=%0d want=%0d", name, pulse_count, model_edges(b)); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_idle got=%b want=0", name, busy); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL %s_drain got=%b want=0", name, out_valid); end
  endtask

  task automatic test_saturation;
    single_window({W{1'b1}}, "saturation");
  endtask

  task automatic test_alternating;
    logic [W-1:0] b;
    for (int i = 0; i < W; i++) b[i] = (i % 2 == 0);
    single_window(b, "alternating");
  endtask

  task automatic test_random_single;
    logic [W-1:0] b;
    for (int k = 0; k < 6; k++) begin
      b = W'($urandom());
      single_window(b, "random_single");
    end
  endtask

  task automatic test_back_to_back;
    cont = 1'b1;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin bit_in = 1'b0; tick(); end
    n_cmp++; if (out_valid !== 1'b1 || count_out !== 5'd0) begin n_bad++; $display("FAIL b2b_first got=%b/%0d want=1/0", out_valid, count_out); end
    out_ready = 1'b0;
    for (int i = 0; i < W; i++) begin
      bit_in = 1'b1;
      if (i == W - 1) begin out_ready = 1'b1; cont = 1'b0; end
      tick();
      if (i == W - 2) begin
        n_cmp++; if (out_valid !== 1'b1 || count_out !== 5'd0) begin n_bad++; $display("FAIL b2b_hold got=%b/%0d want=1/0", out_valid, count_out); end
      end
    end
    bit_in = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || count_out !== 5'd16) begin n_bad++; $display("FAIL b2b_second got=%b/%0d want=1/16", out_valid, count_out); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun got=%b want=0", overrun); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_random_continuous;
    logic [W-1:0] b;
    cont = 1'b1;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b = W'($urandom());
      for (int i = 0; i < W; i++) begin
        bit_in = b[i];
        if (k == 3 && i == W - 1) cont = 1'b0;
        tick();
      end
      n_cmp++; if (out_valid !== 1'b1 || count_out !== model_ones(b)) begin n_bad++; $display("FAIL cont_window%0d got=%b/%0d want=1/%0d", k, out_valid, count_out, model_ones(b)); end
      n_cmp++; if (pulse_count !== model_edges(b)) begin n_bad++; $display("FAIL cont_pulse%0d got=%0d want=%0d", k, pulse_count, model_edges(b)); end
    end
    bit_in = 1'b0;
    tick();
  endtask

  task automatic test_overrun;
    logic [W-1:0] a;
    logic [W-1:0] b;
    a = W'($urandom());
    b = ~a;
    cont = 1'b1;
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin bit_in = a[i]; tick(); end
    n_cmp++; if (out_valid !== 1'b1 || count_out !== model_ones(a) || overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_first got=%b/%0d/%b want=1/%0d/0", out_valid, count_out, overrun, model_ones(a)); end
    for (int i = 0; i < W; i++) begin
      bit_in = b[i];
      if (i == W - 1) cont = 1'b0;
      tick();
    end
    bit_in = 1'b0;
    n_cmp++; if (count_out !== model_ones(a) || pulse_count !== model_edges(a)) begin n_bad++; $display("FAIL ovr_held got=%0d/%0d want=%0d/%0d", count_out, pulse_count, model_ones(a), model_edges(a)); end
    n_cmp++; if (overrun !== 1'b1 || out_valid !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL ovr_flag got=%b/%b/%b want=1/1/0", overrun, out_valid, busy); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (overrun !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL ovr_clear got=%b/%b want=0/1", overrun, busy); end
    out_ready = 1'b1;
    for (int i = 0; i < W; i++) begin bit_in = 1'b0; tick(); end
    n_cmp++; if (out_valid !== 1'b1 || count_out !== 5'd0) begin n_bad++; $display("FAIL ovr_next got=%b/%0d want=1/0", out_valid, count_out); end
    tick();
  endtask

  task automatic test_reset_mid;
    logic seen;
    cont = 1'b1;
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin bit_in = 1'b1; tick(); end
    n_cmp++; if (out_valid !== 1'b1 || count_out !== 5'd16) begin n_bad++; $display("FAIL rstmid_pre got=%b/%0d want=1/16", out_valid, count_out); end
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || count_out !== '0 || pulse_count !== '0) begin n_bad++; $display("FAIL rstmid_data got=%b/%0d/%0d want=0/0/0", out_valid, count_out, pulse_count); end
    n_cmp++; if (overrun !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_flags got=%b/%b want=0/0", overrun, busy); end
    tick();
    tick();
    rst = 1'b1;
    cont = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      bit_in = i[0];
      tick();
      seen |= out_valid | busy;
    end
    bit_in = 1'b0;
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rstmid_quiet got=%b want=0", seen); end
  endtask

  task automatic test_ignored_start;
    logic [W-1:0] b;
    b = W'($urandom());
    cont = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    for (int i = 0; i < W; i++) begin
      start = (i == 4);
      bit_in = b[i];
      tick();
      if (i == W - 2) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ign_early got=%b want=0", out_valid); end
      end
    end
    start = 1'b0;
    bit_in = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || count_out !== model_ones(b)) begin n_bad++; $display("FAIL ign_result got=%b/%0d want=1/%0d", out_valid, count_out, model_ones(b)); end
    for (int i = 0; i < 3; i++) tick();
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL ign_single got=%b/%b want=0/0", busy, out_valid); end
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_alternating();
    test_random_single();
    test_back_to_back();
    test_random_continuous();
    test_overrun();
    test_reset_mid();
    test_ignored_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sc_stream_decoder.md
# sc_stream_decoder

Downstream consumer of the stochastic pulse-to-bitstream stage. Counts the 1s in a unipolar stochastic bit stream over a fixed window of `WINDOW` clock cycles. Each window count is presented as a binary value on a valid/ready output port. Single-shot or continuous windowing, with sticky overrun detection when the sink back-pressures.

## Interface
Parameters:
- `WINDOW`, default 256: samples per window; legal range 2..65535.
- `CW`, default `$clog2(WINDOW+1)`: count width; derived, not overridden.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `bit_in`  in  1  stochastic bit stream; sampled every `ACCUM` cycle.
- `start`  in  1  begin a window; honoured only in `IDLE`.
- `cont`  in  1  continuous mode; sampled at each window end.
- `out_ready`  in  1  sink accepts the result.
- `out_valid`  out  1  result held on `count_out`.
- `count_out`  out  CW  number of 1s in the window, 0..WINDOW.
- `pulse_count`  out  CW  rising edges of `bit_in` in the window; see Configuration.
- `overrun`  out  1  sticky flag: a completed window was dropped.
- `busy`  out  1  high while in `ACCUM`.

## Operation
- FSM with two states:
  - `IDLE`: goes to `ACCUM` when `start`=1. This clears the accumulator, the sample counter, the edge history and `overrun`.
  - `ACCUM`: samples `bit_in` for exactly `WINDOW` cycles.
- Final `ACCUM` cycle:
  - The result `acc + bit_in` loads into the output register.
  - If `cont`=1, stay in `ACCUM` with the accumulator cleared; the next window starts on the following cycle with no gap.
  - If `cont`=0, go to `IDLE`.
- `start` during `ACCUM` is ignored. `cont` dropping mid-window lets the current window finish.
- Arithmetic: the accumulator is `CW` bits and saturates naturally at `WINDOW`; it never wraps. The sample counter is `CW` bits and runs 0..WINDOW-1.
- Output handshake:
  - A transfer occurs on the edge where `out_valid` and `out_ready` are both 1.
  - `out_valid` deasserts after a transfer unless a new result loads on the same edge.
  - `count_out` is stable while `out_valid`=1 and `out_ready`=0.
- Window completing while `out_valid`=1 and `out_ready`=0:
  - The new result is dropped and the old result is held.
  - `overrun` is set to 1 and stays set until reset or the next `start` from `IDLE`.
- Window completing on the same edge as a transfer: the new result loads, `out_valid` stays 1, and there is no overrun.
- Reset values: `out_valid`=0, `count_out`=0, `pulse_count`=0, `overrun`=0, `busy`=0, FSM=`IDLE`.
- Reset asserted mid-window: the partial window is discarded and no result is emitted.

## Timing
- Given `start`=1 at edge T0:
  - `busy`=1 from T0.
  - The first sample is taken at edge T1 and the last at edge T`WINDOW`.
  - `out_valid`=1 after edge T`WINDOW`.
- Latency from `start` to `out_valid` is `WINDOW` cycles.
- In continuous mode a new result is available every `WINDOW` cycles.
- `out_valid` does not depend combinationally on `out_ready`. All outputs are registered.

## Configuration
- Macro `SC_DECODE_PULSECNT_EN`.
- Defined:
  - `pulse_count` reports 0→1 transitions of `bit_in` within the window.
  - The previous-sample register is cleared at window start, so a 1 on the first sample counts as one edge.
  - `pulse_count` loads and is dropped together with `count_out`, under the same handshake.
- Not defined: `pulse_count` is tied to 0 and no edge logic is synthesised. The port list is unchanged.

## Test plan
- Saturation: `WINDOW`=16, `bit_in`=1 constant, `start` pulse, `out_ready`=1.
  - `out_valid` is asserted 16 cycles after `start`, with `count_out`=16.
  - With the macro defined, `pulse_count`=1.
- Alternating input: `WINDOW`=16, `bit_in`=1,0,1,0,… starting with 1.
  - `count_out`=8.
  - With the macro defined, `pulse_count`=8.
- Continuous back-to-back: `cont`=1, `out_ready`=1, windows of all-0 then all-1.
  - Successive results are 0 then 16, exactly 16 cycles apart.
  - `out_valid` stays 1 across the reload edge and `overrun` stays 0.
- Backpressure overrun: `cont`=1, `out_ready`=0 for two windows.
  - The first result is held unchanged and `overrun`=1 after the second window ends.
  - `start` from `IDLE` clears `overrun` to 0.
- Reset mid-window: `rst` driven low at sample 7 of 16.
  - All outputs read 0 immediately.
  - After release, no `out_valid` appears without a new `start`.
- Ignored start: `start` re-asserted at sample 5 of the window.
  - The window still ends at sample 16 with a single result.
